tx_slot_writer: RTL and testbench

TX_SLOT_WRITER -- requirements
Module: tx_slot_writer

---
 rtl/tx_slot_writer_pkg.sv | 42 ++++
 rtl/tx_slot_writer_if.sv | 40 ++++
 rtl/tx_slot_writer.sv | 199 +++++++++++++++++++
 tb/tb_tx_slot_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_slot_writer_pkg.sv
// tx_slot_writer_pkg
// Shared definitions for the TX slot ring writer and the software/hardware
// sender that parses the ring. It holds the header size, the header word index
// map, the writer FSM state encoding, and small record-size/counter helpers.
package tx_slot_writer_pkg;

    // Each ring record starts with this many 16-bit header words
    localparam int HDR_WORDS = 7;

    // Header word order inside a record (offset from the record start)
    localparam logic [2:0] HDR_IDX_LEN      = 3'd0;
    localparam logic [2:0] HDR_IDX_TS_63_48 = 3'd1;
    localparam logic [2:0] HDR_IDX_TS_47_32 = 3'd2;
    localparam logic [2:0] HDR_IDX_TS_31_16 = 3'd3;
    localparam logic [2:0] HDR_IDX_TS_15_0  = 3'd4;
    localparam logic [2:0] HDR_IDX_HASH_HI  = 3'd5;
    localparam logic [2:0] HDR_IDX_HASH_LO  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_COMMIT  = 3'd4
    } state_e;

    // Payload words for a byte length: ceil(len/2), cannot overflow 16 bits
    function automatic logic [15:0] payload_words(input logic [15:0] len);
        return {1'b0, len[15:1]} + {15'd0, len[0]};
    endfunction

    // Whole record size in words: header plus payload
    function automatic logic [16:0] record_words(input logic [15:0] len);
        return 17'(HDR_WORDS) + {1'b0, payload_words(len)};
    endfunction

    // Saturating 16-bit increment for event counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? 16'hFFFF : value + 16'd1;
    endfunction

endpackage

// File: rtl/tx_slot_writer_if.sv
// tx_slot_writer_if
// Bundles the descriptor handshake, payload stream and ring write port of the
// TX slot writer.
//   desc_*  : descriptor (len, timestamp/command word, hash) with valid/ready
//   pl_*    : 16-bit payload words, byte [15:8] first, pl_last on final word
//   slot_*  : ring write port (data, byte enables, address, write strobe)
// Modport slave is the writer itself; master is the frame source / ring side.
interface tx_slot_writer_if #(
    parameter int PTR_W = 14
) ();
    logic             desc_valid;
    logic             desc_ready;
    logic [15:0]      desc_len;
    logic [63:0]      desc_ts;
    logic [31:0]      desc_hash;

    logic             pl_valid;
    logic             pl_ready;
    logic [15:0]      pl_data;
    logic             pl_last;

    logic [15:0]      slot_tx_eth_data;
    logic [1:0]       slot_tx_eth_byte_en;
    logic [PTR_W-1:0] slot_tx_eth_addr;
    logic             slot_tx_eth_wr_en;

    modport slave (
        input  desc_valid, desc_len, desc_ts, desc_hash,
        input  pl_valid, pl_data, pl_last,
        output desc_ready, pl_ready,
        output slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr, slot_tx_eth_wr_en
    );

    modport master (
        output desc_valid, desc_len, desc_ts, desc_hash,
        output pl_valid, pl_data, pl_last,
        input  desc_ready, pl_ready,
        input  slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr, slot_tx_eth_wr_en
    );
endinterface

// File: rtl/tx_slot_writer.sv
// tx_slot_writer
// Writes accepted TX frames into a 16-bit-word ring as records of
// {len, ts x4, hash x2, payload}, and publishes a record to the consumer only
// by advancing mem_wr_ptr once the whole record is in the ring.
// Ports:
//   gmii_tx_clk : clock (rising edge)
//   sys_rst     : asynchronous active-high reset
//   bus         : descriptor / payload / ring write port (slave modport)
//   mem_wr_ptr  : committed write pointer (out)
//   mem_rd_ptr  : consumer's committed read pointer (in)
//   drop_count  : rejected or aborted frames, saturating (out)
//   err         : one-cycle pulse per malformed payload (out)
module tx_slot_writer
    import tx_slot_writer_pkg::*;
#(
    parameter int PTR_W   = 14,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic             gmii_tx_clk,
    input  logic             sys_rst,
    tx_slot_writer_if.slave  bus,
    output logic [PTR_W-1:0] mem_wr_ptr,
    input  logic [PTR_W-1:0] mem_rd_ptr,
    output logic [15:0]      drop_count,
    output logic             err
);

    state_e           state_q;
    logic [PTR_W-1:0] wa_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [15:0]      len_q;
    logic [63:0]      ts_q;
    logic [31:0]      hash_q;
    logic [2:0]       hdr_idx_q;
    logic [15:0]      words_q;
    logic [15:0]      cnt_q;
    logic [15:0]      drop_q;
    logic             err_q;
    logic [15:0]      data_q;
    logic [1:0]       be_q;
    logic [PTR_W-1:0] addr_q;
    logic             wr_en_q;

    logic [PTR_W-1:0] free_s;
    logic [16:0]      need_s;
    logic             len_ok_s;
    logic             room_s;
    logic             desc_ready_s;
    logic             pl_ready_s;
    logic             desc_fire_s;
    logic             pl_fire_s;
    logic             last_expected_s;
    logic [15:0]      hdr_word_s;

    // One word is always kept empty so equal pointers mean an empty ring
    assign free_s   = mem_rd_ptr - wr_ptr_q - {{(PTR_W-1){1'b0}}, 1'b1};
    assign need_s   = record_words(bus.desc_len);
    assign len_ok_s = (bus.desc_len >= 16'(MIN_LEN)) && (bus.desc_len <= 16'(MAX_LEN));
    assign room_s   = 32'(free_s) >= 32'(need_s);

    // Descriptor ready: bad lengths are always taken (to be drained), good ones wait for room
    always_comb begin
        desc_ready_s = 1'b0;
        if (sys_rst) begin
            desc_ready_s = 1'b0;
        end else if (state_q != ST_IDLE) begin
            desc_ready_s = 1'b0;
        end else if (!len_ok_s) begin
            desc_ready_s = 1'b1;
        end else begin
            desc_ready_s = room_s;
        end
    end

    assign pl_ready_s      = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
    assign desc_fire_s     = bus.desc_valid && desc_ready_s;
    assign pl_fire_s       = bus.pl_valid && pl_ready_s;
    assign last_expected_s = (cnt_q == words_q - 16'd1);

    // Header word selected by the header index
    always_comb begin
        hdr_word_s = 16'h0000;
        case (hdr_idx_q)
            HDR_IDX_LEN:      hdr_word_s = len_q;
            HDR_IDX_TS_63_48: hdr_word_s = ts_q[63:48];
            HDR_IDX_TS_47_32: hdr_word_s = ts_q[47:32];
            HDR_IDX_TS_31_16: hdr_word_s = ts_q[31:16];
            HDR_IDX_TS_15_0:  hdr_word_s = ts_q[15:0];
            HDR_IDX_HASH_HI:  hdr_word_s = hash_q[31:16];
            HDR_IDX_HASH_LO:  hdr_word_s = hash_q[15:0];
            default:          hdr_word_s = 16'h0000;
        endcase
    end

    // Writer FSM with registered ring-port, pointer and status outputs
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            wa_q      <= '0;
            wr_ptr_q  <= '0;
            len_q     <= 16'd0;
            ts_q      <= 64'd0;
            hash_q    <= 32'd0;
            hdr_idx_q <= 3'd0;
            words_q   <= 16'd0;
            cnt_q     <= 16'd0;
            drop_q    <= 16'd0;
            err_q     <= 1'b0;
            data_q    <= 16'd0;
            be_q      <= 2'b00;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (desc_fire_s) begin
                        if (!len_ok_s) begin
                            drop_q  <= sat_inc16(drop_q);
                            state_q <= ST_DRAIN;
                        end else begin
                            len_q     <= bus.desc_len;
                            ts_q      <= bus.desc_ts;
                            hash_q    <= bus.desc_hash;
                            words_q   <= payload_words(bus.desc_len);
                            cnt_q     <= 16'd0;
                            hdr_idx_q <= 3'd0;
                            wa_q      <= wr_ptr_q;
                            state_q   <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    wr_en_q <= 1'b1;
                    be_q    <= 2'b11;
                    addr_q  <= wa_q;
                    data_q  <= hdr_word_s;
                    wa_q    <= wa_q + {{(PTR_W-1){1'b0}}, 1'b1};
                    if (hdr_idx_q == HDR_IDX_HASH_LO) begin
                        state_q <= ST_PAYLOAD;
                    end else begin
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (pl_fire_s) begin
                        if (bus.pl_last && !last_expected_s) begin
                            // Short frame: abandon the record, nothing was published
                            err_q   <= 1'b1;
                            drop_q  <= sat_inc16(drop_q);
                            state_q <= ST_IDLE;
                        end else if (!bus.pl_last && last_expected_s) begin
                            // Long frame: swallow the rest up to its pl_last
                            err_q   <= 1'b1;
                            drop_q  <= sat_inc16(drop_q);
                            state_q <= ST_DRAIN;
                        end else begin
                            wr_en_q <= 1'b1;
                            addr_q  <= wa_q;
                            data_q  <= bus.pl_data;
                            be_q    <= (last_expected_s && len_q[0]) ? 2'b10 : 2'b11;
                            wa_q    <= wa_q + {{(PTR_W-1){1'b0}}, 1'b1};
                            cnt_q   <= cnt_q + 16'd1;
                            if (last_expected_s) begin
                                state_q <= ST_COMMIT;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pl_fire_s && bus.pl_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    // wa_q has advanced by exactly one record from the start pointer
                    wr_ptr_q <= wa_q;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.desc_ready          = desc_ready_s;
    assign bus.pl_ready            = pl_ready_s;
    assign bus.slot_tx_eth_data    = data_q;
    assign bus.slot_tx_eth_byte_en = be_q;
    assign bus.slot_tx_eth_addr    = addr_q;
    assign bus.slot_tx_eth_wr_en   = wr_en_q;
    assign mem_wr_ptr              = wr_ptr_q;
    assign drop_count              = drop_q;
    assign err                     = err_q;

endmodule

// File: tb/tb_tx_slot_writer.sv
module tb_tx_slot_writer;
    localparam int PTR_W = 14;
    localparam int RING  = 16384;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PTR_W-1:0] mem_wr_ptr;
    logic [PTR_W-1:0] mem_rd_ptr;
    logic [15:0]      drop_count;
    logic             err;

    tx_slot_writer_if #(.PTR_W(PTR_W)) bus ();

    tx_slot_writer #(.PTR_W(PTR_W), .MIN_LEN(60), .MAX_LEN(1514)) dut (
        .gmii_tx_clk (clk),
        .sys_rst     (rst),
        .bus         (bus),
        .mem_wr_ptr  (mem_wr_ptr),
        .mem_rd_ptr  (mem_rd_ptr),
        .drop_count  (drop_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // ring-port observer
    int               cyc         = 0;
    int               last_wr_cyc = -1;
    int               ptr_chg_cyc = -1;
    int               err_seen    = 0;
    logic [PTR_W-1:0] ptr_prev    = '0;
    logic [PTR_W-1:0] cap_addr[$];
    logic [15:0]      cap_data[$];
    logic [1:0]       cap_be[$];

    always @(negedge clk) begin
        if (bus.slot_tx_eth_wr_en === 1'b1) begin
            cap_addr.push_back(bus.slot_tx_eth_addr);
            cap_data.push_back(bus.slot_tx_eth_data);
            cap_be.push_back(bus.slot_tx_eth_byte_en);
            last_wr_cyc = cyc;
        end
        if (err === 1'b1) err_seen++;
        if (mem_wr_ptr !== ptr_prev) begin
            ptr_chg_cyc = cyc;
            ptr_prev    = mem_wr_ptr;
        end
        cyc++;
    end

    // reference state
    int model_ptr  = 0;
    int model_drop = 0;
    int model_err  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit is_desc, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if ((is_desc ? bus.desc_ready : bus.pl_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(tag, {63'd0, ok}, 64'd1);
        if (ok) tick();
    endtask

    // Sends one frame and checks the ring against a record built from the frame rules
    task automatic run_frame(input int len, input int n_send, input int last_at);
        int          nw;
        bit          in_range;
        bit          commit;
        bit          bad;
        bit          ok;
        logic [63:0] ts;
        logic [31:0] hash;
        logic [15:0] w;
        logic [15:0] l16;
        logic [15:0] exp_data[$];
        nw       = (len + 1) / 2;
        in_range = (len >= 60) && (len <= 1514);
        commit   = in_range && (last_at == nw - 1);
        bad      = in_range && !commit;
        ts       = {$urandom(), $urandom()};
        hash     = $urandom();
        l16      = 16'(len);
        cap_addr.delete();
        cap_data.delete();
        cap_be.delete();
        bus.desc_len   = l16;
        bus.desc_ts    = ts;
        bus.desc_hash  = hash;
        bus.desc_valid = 1'b1;
        wait_rdy(1'b1, "desc_ready", ok);
        bus.desc_valid = 1'b0;
        if (!ok) return;
        exp_data = {l16, ts[63:48], ts[47:32], ts[31:16], ts[15:0], hash[31:16], hash[15:0]};
        for (int k = 0; k < n_send; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.pl_valid = 1'b0;
                tick();
            end
            w            = 16'($urandom());
            bus.pl_valid = 1'b1;
            bus.pl_data  = w;
            bus.pl_last  = (k == last_at);
            if (k < nw) exp_data.push_back(w);
            wait_rdy(1'b0, "pl_ready", ok);
            if (!ok) begin
                bus.pl_valid = 1'b0;
                return;
            end
        end
        bus.pl_valid = 1'b0;
        bus.pl_last  = 1'b0;
        repeat (4) tick();
        if (!in_range || bad) model_drop++;
        if (bad) model_err++;
        if (commit) begin
            chk("wr_count", cap_addr.size(), exp_data.size());
            for (int i = 0; i < exp_data.size() && i < cap_addr.size(); i++) begin
                chk("wr_addr", cap_addr[i], (model_ptr + i) % RING);
                chk("wr_data", cap_data[i], exp_data[i]);
                chk("wr_be", cap_be[i], ((i == exp_data.size() - 1) && (len % 2 == 1)) ? 2 : 3);
            end
            model_ptr = (model_ptr + 7 + nw) % RING;
            chk("commit_lag", ptr_chg_cyc, last_wr_cyc + 1);
        end else if (!in_range) begin
            chk("drain_writes", cap_addr.size(), 0);
        end
        chk("mem_wr_ptr", mem_wr_ptr, model_ptr);
        chk("drop_count", drop_count, model_drop);
        chk("err_pulses", err_seen, model_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem;
        int n;
        int len;
        bit ok;
        int guard;
        bus.desc_valid = 1'b0;
        bus.desc_len   = 16'd0;
        bus.desc_ts    = 64'd0;
        bus.desc_hash  = 32'd0;
        bus.pl_valid   = 1'b0;
        bus.pl_data    = 16'd0;
        bus.pl_last    = 1'b0;
        mem_rd_ptr     = '0;
        repeat (2) tick();

        // reset state
        chk("rst_desc_ready", bus.desc_ready, 0);
        chk("rst_pl_ready", bus.pl_ready, 0);
        chk("rst_wr_en", bus.slot_tx_eth_wr_en, 0);
        chk("rst_addr", bus.slot_tx_eth_addr, 0);
        chk("rst_data", bus.slot_tx_eth_data, 0);
        chk("rst_be", bus.slot_tx_eth_byte_en, 0);
        chk("rst_wr_ptr", mem_wr_ptr, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // nominal even and odd frames on an empty ring
        mem_rd_ptr = PTR_W'(model_ptr);
        run_frame(60, 30, 29);
        mem_rd_ptr = PTR_W'(model_ptr);
        run_frame(61, 31, 30);

        // malformed payloads and out-of-range lengths
        mem_rd_ptr = PTR_W'(model_ptr);
        run_frame(60, 10, 9);
        run_frame(60, 33, 32);
        run_frame(59, 30, 29);
        run_frame(1515, 758, 757);
        mem_rd_ptr = PTR_W'(model_ptr);
        run_frame(62, 31, 30);

        // insufficient space holds the descriptor until the reader frees enough
        mem_rd_ptr     = PTR_W'(model_ptr + 20);
        bus.desc_len   = 16'd60;
        bus.desc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_hold", bus.desc_ready, 0);
            tick();
        end
        mem_rd_ptr = PTR_W'(model_ptr + 37);
        #1;
        chk("bp_one_short", bus.desc_ready, 0);
        mem_rd_ptr = PTR_W'(model_ptr + 38);
        #1;
        chk("bp_release", bus.desc_ready, 1);
        bus.desc_valid = 1'b0;
        tick();
        run_frame(60, 30, 29);

        // random-length frames that bring the write pointer to 16380
        guard = 0;
        while (model_ptr != 16380 && guard < 200) begin
            guard++;
            rem = 16380 - model_ptr;
            if (rem > 801) n = $urandom_range(37, 764);
            else if (rem > 764) n = rem - 37;
            else n = rem;
            len = 2 * (n - 7);
            if (n > 37 && $urandom_range(0, 1) == 1) len = len - 1;
            mem_rd_ptr = PTR_W'(model_ptr);
            run_frame(len, (len + 1) / 2, (len + 1) / 2 - 1);
        end
        chk("filler_ptr", mem_wr_ptr, 16380);

        // record straddling the top of the ring
        mem_rd_ptr = PTR_W'(model_ptr);
        run_frame(64, 32, 31);

        // reset in the middle of a payload
        mem_rd_ptr     = PTR_W'(model_ptr);
        bus.desc_len   = 16'd100;
        bus.desc_valid = 1'b1;
        wait_rdy(1'b1, "mr_desc_ready", ok);
        bus.desc_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.pl_valid = 1'b1;
            bus.pl_data  = 16'($urandom());
            bus.pl_last  = 1'b0;
            wait_rdy(1'b0, "mr_pl_ready", ok);
        end
        chk("mr_pre_wr_en", bus.slot_tx_eth_wr_en, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_wr_en", bus.slot_tx_eth_wr_en, 0);
        chk("mr_addr", bus.slot_tx_eth_addr, 0);
        chk("mr_data", bus.slot_tx_eth_data, 0);
        chk("mr_be", bus.slot_tx_eth_byte_en, 0);
        chk("mr_wr_ptr", mem_wr_ptr, 0);
        chk("mr_drop", drop_count, 0);
        chk("mr_err", err, 0);
        chk("mr_desc_ready", bus.desc_ready, 0);
        chk("mr_pl_ready", bus.pl_ready, 0);
        bus.pl_valid = 1'b0;
        tick();
        tick();
        rst        = 1'b0;
        model_ptr  = 0;
        model_drop = 0;
        tick();

        // fresh frame after reset starts at address 0
        mem_rd_ptr = '0;
        run_frame(60, 30, 29);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
